// File: rtl/fdma_read_interconnect.sv
// N-channel FDMA read arbiter: grants one burst at a time (round-robin or fixed priority),
// forwards the winner's address/size and routes read beats back with length checking.
module fdma_read_interconnect #(
  parameter int unsigned CH_NUM         = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 23,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned ARB_MODE       = 0
) (
  input  logic                             ui_clk,
  input  logic                             ui_rstn,
  input  logic [CH_NUM*AXI_ADDR_WIDTH-1:0] ch_raddr,
  input  logic [CH_NUM-1:0]                ch_rareq,
  input  logic [CH_NUM*16-1:0]             ch_rsize,
  output logic [CH_NUM-1:0]                ch_rbusy,
  output logic [AXI_DATA_WIDTH-1:0]        ch_rdata,
  output logic [CH_NUM-1:0]                ch_rvalid,
  output logic [AXI_ADDR_WIDTH-1:0]        fdma_raddr,
  output logic                             fdma_rareq,
  output logic [15:0]                      fdma_rsize,
  input  logic                             fdma_rbusy,
  input  logic [AXI_DATA_WIDTH-1:0]        fdma_rdata,
  input  logic                             fdma_rvalid,
  output logic [CH_NUM-1:0]                grant_onehot,
  output logic                             err_len
);

  localparam int unsigned IW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StBusy, StDone} state_e;

  state_e              state;
  logic [IW-1:0]       last_grant;
  logic [IW-1:0]       win_idx;
  logic [IW-1:0]       cand;
  logic                any_req;
  logic [CH_NUM-1:0]   gnt_oh;
  logic [15:0]         beat_cnt;
  logic [15:0]         rsize_q;
  logic [AXI_ADDR_WIDTH-1:0] win_addr;
  logic [15:0]         win_size;

  // Winner selection; loops run downward so the last hit is the highest-priority candidate.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    any_req = |ch_rareq;
    if (ARB_MODE == 1) begin
      for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
        cand = IW'(i);
        if (ch_rareq[cand]) win_idx = cand;
      end
    end else begin
      for (int i = int'(CH_NUM); i >= 1; i--) begin
        cand = IW'((int'(last_grant) + i) % int'(CH_NUM));
        if (ch_rareq[cand]) win_idx = cand;
      end
    end
  end

  assign win_addr = ch_raddr[int'(win_idx)*int'(AXI_ADDR_WIDTH) +: AXI_ADDR_WIDTH];
  assign win_size = ch_rsize[int'(win_idx)*16 +: 16];

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      state      <= StIdle;
      last_grant <= IW'(CH_NUM - 1);
      gnt_oh     <= '0;
      beat_cnt   <= '0;
      rsize_q    <= '0;
      fdma_raddr <= '0;
      fdma_rareq <= 1'b0;
      ch_rvalid  <= '0;
      ch_rdata   <= '0;
      err_len    <= 1'b0;
    end else begin
      err_len   <= 1'b0;
      ch_rvalid <= '0;
      unique case (state)
        StIdle: begin
          if (any_req) begin
            fdma_raddr <= win_addr;
            rsize_q    <= win_size;
            gnt_oh     <= CH_NUM'(1) << win_idx;
            beat_cnt   <= '0;
            last_grant <= win_idx;
            // Zero-length requests are acknowledged without touching the FDMA port.
            if (win_size != 16'd0) begin
              fdma_rareq <= 1'b1;
              state      <= StReq;
            end else begin
              state      <= StDone;
            end
          end
        end
        StReq: begin
          if (fdma_rbusy) begin
            fdma_rareq <= 1'b0;
            state      <= StBusy;
          end
        end
        StBusy: begin
          if (fdma_rvalid) begin
            ch_rvalid <= gnt_oh;
            ch_rdata  <= fdma_rdata;
            beat_cnt  <= beat_cnt + 16'd1;
          end
          if (!fdma_rbusy) state <= StDone;
        end
        StDone: begin
          gnt_oh  <= '0;
          err_len <= (beat_cnt != rsize_q);
          state   <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign ch_rbusy     = gnt_oh;
  assign grant_onehot = gnt_oh;
  assign fdma_rsize   = rsize_q;

endmodule
